trng_word_buffer: RTL and testbench
===================================

Name: trng_word_buffer

Overview:
- Downstream consumer of the RO word assembler: takes 32-bit entropy words plus a one-cycle valid pulse and buffers them in a small FIFO.
- Runs a repetition-count health test on the incoming words and exposes a single-cycle-latency pop interface plus status flags.
- The PicoRV32 peripheral wrapper reads these through its MMIO registers.
- The producer cannot stall, so there is no backpressure: overflow is dropped and flagged.

Parameters:
- DEPTH, 8: FIFO entries. Power of two, minimum 2.
- REP_LIMIT, 4: number of consecutive identical accepted words that trips health_fail. Minimum 2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset. Asserted when 0, released synchronously to clk by upstream.
- in_data  in  32  entropy word from the assembler.
- in_valid  in  1  one-cycle pulse; in_data is valid this cycle.
- rd_en  in  1  pop request from the bus wrapper.
- rd_data  out  32  popped word; registered.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- clr  in  1  synchronous flush of the FIFO plus clear of all sticky flags and health state.
- count  out  $clog2(DEPTH+1)  current occupancy.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- health_fail  out  1  sticky: repetition test tripped.

Behaviour:
- Reset (rst=0), asynchronous:
  - wr_ptr, rd_ptr, count = 0; empty=1, full=0.
  - rd_data=0, rd_valid=0, overflow=0, health_fail=0.
  - last_word=0, last_vld=0, rep_cnt=0.
  - Storage contents are don't-care.
  - Reset mid-transfer discards all buffered words.
- Push, on a cycle with in_valid=1:
  - Priority: clr, then health_fail, then full.
  - If clr=1: the word is dropped and no flag is set.
  - Else if health_fail=1: the word is dropped silently. Overflow is not set and rep state is not updated.
  - Else the health test evaluates first. If the word trips the test, it is not written.
  - Else if full and no simultaneous pop: the word is dropped and overflow is set to 1.
  - Else: written at wr_ptr, wr_ptr wraps modulo DEPTH.
- Health test (repetition count), on a push with clr=0 and health_fail=0:
  - If last_vld and in_data==last_word: rep_cnt+1.
  - Otherwise: rep_cnt=1, last_word=in_data, last_vld=1.
  - When the new rep_cnt reaches REP_LIMIT: health_fail is set from the next cycle and the word is discarded.
  - rep_cnt saturates and never exceeds REP_LIMIT.
- Pop:
  - rd_en=1 with empty=0 and clr=0: rd_data <= mem[rd_ptr] and rd_valid=1 on the next cycle. rd_ptr wraps.
  - rd_en while empty: no effect, rd_valid=0, rd_data holds.
  - rd_valid is high for exactly one cycle per pop. rd_data holds between pops.
- Simultaneous push and pop:
  - When full: both proceed; count unchanged; no overflow.
  - When empty: push only. There is no bypass, so rd_valid=0.
  - Otherwise: count unchanged.
- count, empty and full are registered and consistent with the pointers every cycle.
- Pointer width is $clog2(DEPTH). Occupancy is tracked by the count register, not pointer comparison.
- clr=1, synchronous:
  - Next cycle: pointers=0, count=0, overflow=0, health_fail=0, last_vld=0, rep_cnt=0, rd_valid=0.
  - clr overrides any simultaneous push or pop.
- Sticky flags remain set until clr or reset. Health_fail also blocks all further pushes.

Optional Feature:
- Macro TRNG_HEALTH_EN.
- Defined: the repetition-count test and health_fail behave as above.
- Undefined: no test logic or last_word/rep_cnt registers are built; health_fail is tied 0 and every accepted word follows full/overflow rules only.

Decomposition:
- Package trng_pkg:
  - TRNG_WORD_W=32.
  - TRNG_FIFO_DEPTH_DEF=8.
  - TRNG_REP_LIMIT_DEF=4.
  - Shared by assembler, buffer and bus wrapper.
- Sub-module trng_fifo_mem:
  - DEPTH x 32 storage with one write port and one registered read port.
  - Holds no flag or pointer logic.
  - The top holds pointers, count, flags and health test.

Test Plan:
- After reset: push 0x11111111, 0x22222222, 0x33333333 → count=3. Three rd_en pulses give rd_data in FIFO order, each with a 1-cycle rd_valid one cycle after rd_en; empty=1 at the end.
- Push 9 distinct words with DEPTH=8 and no pops → full=1, count=8, overflow=1. The 9th word is never read; pops return words 1..8.
- Full FIFO, with in_valid and rd_en in the same cycle → count stays 8, overflow stays 0, new word appears last.
- TRNG_HEALTH_EN defined, REP_LIMIT=4: push 0xDEADBEEF four times → first three are stored (count=3), 4th trips health_fail=1. A subsequent push of 0x12345678 is dropped and overflow=0.
- TRNG_HEALTH_EN undefined: same stimulus → count=4, health_fail=0.
- With health_fail=1, overflow=1 and count=5: pulse clr with in_valid=1 → next cycle count=0, empty=1, all flags 0, word dropped. Separately, rst=0 mid-pop gives rd_valid=0 and rd_data=0 immediately.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG entropy path: assembler, word buffer and bus wrapper.
`timescale 1ns/1ps
package trng_pkg;

    localparam int TRNG_WORD_W         = 32;
    localparam int TRNG_FIFO_DEPTH_DEF = 8;
    localparam int TRNG_REP_LIMIT_DEF  = 4;

    typedef logic [TRNG_WORD_W-1:0] trng_word_t;

    // Fate of an incoming word, in decreasing priority order.
    typedef enum logic [2:0] {
        PUSH_NONE,
        PUSH_DROP_CLR,
        PUSH_DROP_HEALTH,
        PUSH_DROP_TRIP,
        PUSH_DROP_FULL,
        PUSH_WRITE
    } trng_push_e;

endpackage

// File: rtl/trng_fifo_mem.sv
// DEPTH x word storage: one write port, one registered read port. No pointer or flag logic.
`timescale 1ns/1ps
module trng_fifo_mem
    import trng_pkg::*;
#(
    parameter int DEPTH = TRNG_FIFO_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_wr_en,
    input  logic [AW-1:0]   i_wr_addr,
    input  trng_word_t      i_wr_data,
    input  logic            i_rd_en,
    input  logic [AW-1:0]   i_rd_addr,
    output trng_word_t      o_rd_data
);

    trng_word_t r_mem [DEPTH];
    trng_word_t r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // A same-address write and read (full FIFO, push+pop) returns the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/trng_word_buffer.sv
// Entropy word FIFO with sticky overflow flag and optional repetition-count health test.
// Build option: define TRNG_HEALTH_EN to include the repetition-count test.
`timescale 1ns/1ps
module trng_word_buffer
    import trng_pkg::*;
#(
    parameter int DEPTH     = TRNG_FIFO_DEPTH_DEF,
    parameter int REP_LIMIT = TRNG_REP_LIMIT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [TRNG_WORD_W-1:0]       in_data,
    input  logic                         in_valid,
    input  logic                         rd_en,
    output logic [TRNG_WORD_W-1:0]       rd_data,
    output logic                         rd_valid,
    input  logic                         clr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         health_fail
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_empty;
    logic          r_full;
    logic          r_rd_valid;
    logic          r_overflow;

    logic          w_pop;
    logic          w_push;
    logic          w_trip;
    logic          w_hf;
    logic [CW-1:0] w_count_next;
    trng_push_e    w_push_act;

    assign w_pop = rd_en & ~r_empty & ~clr;

`ifdef TRNG_HEALTH_EN
    localparam int RW = $clog2(REP_LIMIT+1);
    localparam logic [RW-1:0] REP_LIM_V = RW'(REP_LIMIT);

    trng_word_t    r_last_word;
    logic          r_last_vld;
    logic [RW-1:0] r_rep_cnt;
    logic          r_health_fail;
    logic          w_rep_match;
    logic          w_health_upd;
    logic [RW-1:0] w_rep_next;

    assign w_health_upd = in_valid & ~clr & ~r_health_fail;

    always_comb begin
        w_rep_match = r_last_vld && (in_data == r_last_word);
        w_rep_next  = RW'(1);
        if (w_rep_match) begin
            w_rep_next = (r_rep_cnt == REP_LIM_V) ? r_rep_cnt : r_rep_cnt + RW'(1);
        end
        w_trip = w_health_upd && (w_rep_next == REP_LIM_V);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_word   <= '0;
            r_last_vld    <= 1'b0;
            r_rep_cnt     <= '0;
            r_health_fail <= 1'b0;
        end else if (clr) begin
            r_last_vld    <= 1'b0;
            r_rep_cnt     <= '0;
            r_health_fail <= 1'b0;
        end else if (w_health_upd) begin
            r_rep_cnt <= w_rep_next;
            if (!w_rep_match) begin
                r_last_word <= in_data;
                r_last_vld  <= 1'b1;
            end
            if (w_trip) begin
                r_health_fail <= 1'b1;
            end
        end
    end

    assign w_hf = r_health_fail;
`else
    assign w_trip = 1'b0;
    assign w_hf   = 1'b0;
`endif

    always_comb begin
        w_push_act = PUSH_NONE;
        if (in_valid) begin
            if (clr)                    w_push_act = PUSH_DROP_CLR;
            else if (w_hf)              w_push_act = PUSH_DROP_HEALTH;
            else if (w_trip)            w_push_act = PUSH_DROP_TRIP;
            else if (r_full && !w_pop)  w_push_act = PUSH_DROP_FULL;
            else                        w_push_act = PUSH_WRITE;
        end
    end

    assign w_push       = (w_push_act == PUSH_WRITE);
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    // empty/full are registered from the next count so they track the pointers every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count    <= w_count_next;
            r_empty    <= (w_count_next == '0);
            r_full     <= (w_count_next == CW'(DEPTH));
            r_rd_valid <= w_pop;
            if (w_push_act == PUSH_DROP_FULL) r_overflow <= 1'b1;
        end
    end

    trng_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (in_data),
        .i_rd_en   (w_pop),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (rd_data)
    );

    assign rd_valid    = r_rd_valid;
    assign count       = r_count;
    assign empty       = r_empty;
    assign full        = r_full;
    assign overflow    = r_overflow;
    assign health_fail = w_hf;

endmodule

// File: tb/tb_trng_word_buffer.sv
// Scoreboard bench for trng_word_buffer: directed scenarios plus randomized traffic vs a queue model.
`timescale 1ns/1ps
module tb_trng_word_buffer;
    import trng_pkg::*;

    localparam int DEPTH = 8;
    localparam int LIM   = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          rd_en = 1'b0;
    logic          clr = 1'b0;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic [CW-1:0] count;
    logic          empty, full, overflow, health_fail;

    always #5 clk = ~clk;

    trng_word_buffer #(.DEPTH(DEPTH), .REP_LIMIT(LIM)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .clr         (clr),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .health_fail (health_fail)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Scoreboard of words expected on rd_data, in order.
    logic [31:0] exp_q[$];
    // Reference model state.
    logic [31:0] m_fifo[$];
    bit          m_ovf, m_hf, m_lvld;
    logic [31:0] m_last;
    int          m_rep;
    logic [31:0] m_hold;
    bit          mon_en = 1'b0;
    logic [31:0] mon_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        m_ovf = 0; m_hf = 0; m_lvld = 0; m_rep = 0;
        m_last = '0; m_hold = '0;
    endtask

    task automatic model_update(input bit c, input bit iv, input logic [31:0] d, input bit re);
        bit pop;
        bit trip;
        int sz_before;
        pop = 0; trip = 0;
        if (c) begin
            m_fifo.delete();
            m_ovf = 0; m_hf = 0; m_lvld = 0; m_rep = 0;
        end else begin
            sz_before = m_fifo.size();
            pop = re && (sz_before > 0);
            if (pop) exp_q.push_back(m_fifo.pop_front());
            if (iv && !m_hf) begin
`ifdef TRNG_HEALTH_EN
                if (m_lvld && d == m_last) m_rep = (m_rep < LIM) ? m_rep + 1 : LIM;
                else begin
                    m_rep = 1; m_last = d; m_lvld = 1;
                end
                trip = (m_rep == LIM);
                if (trip) m_hf = 1;
`endif
                if (!trip) begin
                    if (sz_before == DEPTH && !pop) m_ovf = 1;
                    else m_fifo.push_back(d);
                end
            end
        end
    endtask

    task automatic step(input bit c, input bit iv, input logic [31:0] d, input bit re);
        @(negedge clk);
        clr = c; in_valid = iv; in_data = d; rd_en = re;
        model_update(c, iv, d, re);
        @(posedge clk);
        #1;
        check("count", 32'(count), 32'(m_fifo.size()));
        check("empty", 32'(empty), 32'(m_fifo.size() == 0));
        check("full", 32'(full), 32'(m_fifo.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("health_fail", 32'(health_fail), 32'(m_hf));
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 0);
    endtask

    // Monitor: every presented rd_valid pops the scoreboard; otherwise rd_data must hold.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("rd_valid_unexpected", 32'(rd_valid), 32'h0);
                end else begin
                    mon_w = exp_q.pop_front();
                    check("rd_data", rd_data, mon_w);
                    m_hold = mon_w;
                end
            end else begin
                check("rd_data_hold", rd_data, m_hold);
            end
        end
    end

    logic [31:0] pool [4] = '{32'hDEADBEEF, 32'h0BADF00D, 32'h5A5A5A5A, 32'h00000001};

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full", 32'(full), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_health_fail", 32'(health_fail), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;

        // In-order push/pop.
        step(0, 1, 32'h11111111, 0);
        step(0, 1, 32'h22222222, 0);
        step(0, 1, 32'h33333333, 0);
        repeat (3) step(0, 0, 32'h0, 1);
        idle();

        // Overflow: nine distinct words, then drain.
        for (int i = 1; i <= 9; i++) step(0, 1, 32'hA0000000 + 32'(i), 0);
        repeat (9) step(0, 0, 32'h0, 1);
        step(1, 0, 32'h0, 0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 1; i <= 8; i++) step(0, 1, 32'hB0000000 + 32'(i), 0);
        step(0, 1, 32'hCAFEF00D, 1);
        repeat (8) step(0, 0, 32'h0, 1);
        idle();

        // Repetition test.
        repeat (4) step(0, 1, 32'hDEADBEEF, 0);
        step(0, 1, 32'h12345678, 0);
        step(1, 0, 32'h0, 0);

        // Both flags raised, then clr with a concurrent push.
        for (int i = 1; i <= 9; i++) step(0, 1, 32'hC0000000 + 32'(i), 0);
        repeat (6) step(0, 0, 32'h0, 1);
        repeat (4) step(0, 1, 32'hDEADBEEF, 0);
        step(1, 1, 32'h77777777, 0);
        check("clr_count", 32'(count), 32'h0);
        check("clr_empty", 32'(empty), 32'h1);
        check("clr_overflow", 32'(overflow), 32'h0);
        check("clr_health_fail", 32'(health_fail), 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] d;
            bit c, iv, re;
            c  = ($urandom_range(0, 47) == 0);
            iv = ($urandom_range(0, 1) == 1);
            re = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) d = pool[$urandom_range(0, 3)];
            else d = $urandom;
            step(c, iv, d, re);
        end
        repeat (2) idle();

        // Asynchronous reset while a pop is being presented.
        step(0, 1, 32'h44444444, 0);
        step(0, 1, 32'h55555555, 0);
        step(0, 0, 32'h0, 1);
        #2;
        rst = 1'b0;
        in_valid = 1'b0; rd_en = 1'b0; clr = 1'b0;
        #1;
        check("arst_rd_valid", 32'(rd_valid), 32'h0);
        check("arst_rd_data", rd_data, 32'h0);
        check("arst_count", 32'(count), 32'h0);
        check("arst_empty", 32'(empty), 32'h1);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(0, 1, 32'h66666666, 0);
        step(0, 0, 32'h0, 1);
        repeat (2) idle();

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
